// File: rtl/bcd2bin_if.sv
// bcd2bin_if: handshake bundle for bcd2bin_converter.
//   in_bcd    packed BCD word, bits [3:0] = least-significant digit
//   in_valid  in_bcd is valid (source holds it until in_ready)
//   in_ready  converter can accept a word
//   out_data  binary result (0 when any digit was invalid)
//   out_error at least one input nibble was > 9
//   out_valid out_data/out_error are valid
//   out_ready consumer accepts the result
// Handshake: a word/result moves on a rising clk edge where valid and
// ready are both high; valid must not drop before that edge and the
// payload must stay stable while valid is high and ready is low.
// master = producer/consumer side (bench), slave = converter side.
interface bcd2bin_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic [4*DIGITS-1:0] in_bcd;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_error;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_bcd, in_valid, out_ready,
    input  in_ready, out_data, out_error, out_valid
  );

  modport slave (
    input  in_bcd, in_valid, out_ready,
    output in_ready, out_data, out_error, out_valid
  );
endinterface

// File: rtl/bcd2bin_converter.sv
// bcd2bin_converter: sequential packed-BCD to binary decoder.
// Consumes one digit per cycle, most-significant first, as
// acc = acc*10 + digit. A word is accepted in IDLE, takes exactly DIGITS
// cycles in CONV, then the result is presented in DONE until taken.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        bcd2bin_if slave modport (input word and result handshakes)
//   state_dbg  current FSM state (IDLE=0, CONV=1, DONE=2)
// All outputs are registered or decoded from state; in_valid/out_ready
// never reach an output combinationally.
// DIGITS >= 1 and 2^WIDTH > 10^DIGITS - 1 are required.
module bcd2bin_converter #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic        clk,
  input  logic        rst,
  bcd2bin_if.slave    bus,
  output logic [1:0]  state_dbg
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   word_q, word_d;
  logic                  err_q, err_d;
  logic [WIDTH-1:0]      data_q, data_d;

  logic [3:0]            nib;
  logic                  in_err;
  logic [WIDTH-1:0]      acc_step;

  // Digit currently selected by the index (MSD first).
  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == i[IDX_W-1:0]) nib = word_q[4*i +: 4];
    end
  end

  // Any non-decimal nibble in the incoming word flags the whole word.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.in_bcd[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  // acc*10 + digit, keeping the low WIDTH bits. Truncation after a wider
  // computation gives the same low bits, so the wide form is not built.
  // Valid words never overflow; invalid words are zeroed at the end.
  assign acc_step = acc_q * WIDTH'(10) + WIDTH'(nib);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    word_d  = word_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = bus.in_bcd;
          acc_d   = '0;
          idx_d   = IDX_W'(DIGITS - 1);
          err_d   = in_err;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = acc_step;
        if (idx_q == '0) begin
          data_d  = err_q ? '0 : acc_step;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_error = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_bcd2bin_converter.sv
module tb_bcd2bin_converter;

  logic clk;
  logic rst;
  logic [1:0] state_dbg4;
  logic [1:0] state_dbg1;

  int checks;
  int failures;

  logic [14:0] exp_q[$];

  bcd2bin_if #(.DIGITS(4), .WIDTH(14)) bus4 ();
  bcd2bin_if #(.DIGITS(1), .WIDTH(4))  bus1 ();

  bcd2bin_converter #(.DIGITS(4), .WIDTH(14)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus4),
    .state_dbg (state_dbg4)
  );

  bcd2bin_converter #(.DIGITS(1), .WIDTH(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .state_dbg (state_dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] data;
    logic        err;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal value as the weighted sum of digits.
  function automatic logic [14:0] ref4(input logic [15:0] w);
    int v;
    bit e;
    int d;
    v = 0;
    e = 0;
    for (int i = 0; i < 4; i++) begin
      d = int'((w >> (4 * i)) & 16'hF);
      if (d > 9) e = 1;
      v = v + d * (10 ** i);
    end
    return e ? {1'b1, 14'd0} : {1'b0, 14'(v)};
  endfunction

  // 4-digit transaction: accept, measure latency, compare, optional
  // backpressure hold (with a competing in_valid), then release.
  task automatic run4(input logic [15:0] bcd, input logic [14:0] exp, input int hold);
    int n;
    logic [14:0] got;
    logic [14:0] want;
    n = 0;
    while (!bus4.in_ready && n < 50) begin step(); n++; end
    check("ready_before_accept", 32'(bus4.in_ready), 32'd1);
    bus4.in_bcd   = bcd;
    bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    exp_q.push_back(exp);
    check("in_ready_low_after_accept", 32'(bus4.in_ready), 32'd0);
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      if (bus4.in_ready) check("in_ready_low_in_conv", 32'(bus4.in_ready), 32'd0);
      step();
      n++;
    end
    check("latency", 32'(n), 32'd4);
    check("out_valid_rise", 32'(bus4.out_valid), 32'd1);
    got = {bus4.out_error, bus4.out_data};
    if (exp_q.size() > 0) want = exp_q.pop_front();
    else want = 15'h7FFF;
    check("result", 32'(got), 32'(want));
    for (int h = 0; h < hold; h++) begin
      bus4.in_bcd   = 16'($urandom_range(0, 65535));
      bus4.in_valid = 1'b1;
      step();
      check("hold_valid", 32'(bus4.out_valid), 32'd1);
      check("hold_result", 32'({bus4.out_error, bus4.out_data}), 32'(got));
      check("hold_in_ready", 32'(bus4.in_ready), 32'd0);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check("release_out_valid", 32'(bus4.out_valid), 32'd0);
    check("release_in_ready", 32'(bus4.in_ready), 32'd1);
  endtask

  task automatic run1(input logic [3:0] d, input logic [4:0] exp);
    int n;
    n = 0;
    while (!bus1.in_ready && n < 50) begin step(); n++; end
    check("d1_ready_before", 32'(bus1.in_ready), 32'd1);
    bus1.in_bcd   = d;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 10) begin step(); n++; end
    check("d1_latency", 32'(n), 32'd1);
    check("d1_result", 32'({bus1.out_error, bus1.out_data}), 32'(exp));
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    check("d1_release_valid", 32'(bus1.out_valid), 32'd0);
    check("d1_release_ready", 32'(bus1.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  d;
    int          n;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus4.in_bcd = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_bcd = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;

    vecs[0] = '{16'h1234, 14'd1234, 1'b0, 0};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0, 0};
    vecs[2] = '{16'h0000, 14'd0,    1'b0, 0};
    vecs[3] = '{16'h0001, 14'd1,    1'b0, 0};
    vecs[4] = '{16'h12A4, 14'd0,    1'b1, 0};
    vecs[5] = '{16'hF000, 14'd0,    1'b1, 0};
    vecs[6] = '{16'h0507, 14'd507,  1'b0, 6};
    vecs[7] = '{16'h0999, 14'd999,  1'b0, 2};

    step(); step();
    rst = 1'b0;
    check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_out_data", 32'(bus4.out_data), 32'd0);
    check("rst_out_error", 32'(bus4.out_error), 32'd0);
    step();
    check("idle_no_valid_stays", 32'(bus4.in_ready), 32'd1);

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run4(vecs[i].bcd, {vecs[i].err, vecs[i].data}, vecs[i].hold);
    end

    // reset during the second CONV cycle
    bus4.in_bcd   = 16'h4321;
    bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    check("mid_accepted", 32'(bus4.in_ready), 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus4.in_ready), 32'd1);
    check("mid_rst_out_data", 32'(bus4.out_data), 32'd0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus4.out_valid) n++;
      step();
    end
    check("mid_rst_no_result", 32'(n), 32'd0);
    run4(16'h0042, {1'b0, 14'd42}, 0);

    // randomized words against the reference model
    for (int k = 0; k < 40; k++) begin
      w = '0;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) w[4*i +: 4] = 4'($urandom_range(10, 15));
        else w[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run4(w, ref4(w), int'($urandom_range(0, 2)));
    end

    // single-digit variant
    run1(4'h7, {1'b0, 4'd7});
    run1(4'hC, {1'b1, 4'd0});
    for (int k = 0; k < 10; k++) begin
      d = 4'($urandom_range(0, 15));
      run1(d, (d > 4'd9) ? {1'b1, 4'd0} : {1'b0, d});
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
